// File: rtl/spi_mem_master.sv
// SPI mode-0 master for a byte-wide serial memory: 8-bit command {addr, rw} then one data byte.
// Optional macro SPIM_CS_GAP_EN inserts a 2*CLKDIV-cycle chip-select-high GAP state after each frame.
module spi_mem_master #(
    parameter int CLKDIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       sclk_pin,
    output logic       cs_pin,
    output logic       mosi_pin,
    input  logic       miso_pin
);

    localparam int DW = $clog2(CLKDIV) + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
`ifdef SPIM_CS_GAP_EN
    localparam logic [DW-1:0] GAP_LAST = DW'(2 * CLKDIV - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_DATA,
`ifdef SPIM_CS_GAP_EN
        S_GAP,
`endif
        S_END
    } state_t;

    state_t      state_reg, state_next;
    logic [DW-1:0] div_reg, div_next;
    logic [4:0]  edge_reg, edge_next;
    logic        sclk_reg, sclk_next;
    logic        cs_reg, cs_next;
    logic        mosi_reg, mosi_next;
    logic [15:0] tx_reg, tx_next;
    logic [7:0]  rx_reg, rx_next;
    logic [7:0]  rdata_reg, rdata_next;
    logic        rw_reg, rw_next;
    logic        done_reg, done_next;
    logic        half_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            div_reg   <= '0;
            edge_reg  <= '0;
            sclk_reg  <= 1'b0;
            cs_reg    <= 1'b1;
            mosi_reg  <= 1'b0;
            tx_reg    <= '0;
            rx_reg    <= '0;
            rdata_reg <= '0;
            rw_reg    <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            div_reg   <= div_next;
            edge_reg  <= edge_next;
            sclk_reg  <= sclk_next;
            cs_reg    <= cs_next;
            mosi_reg  <= mosi_next;
            tx_reg    <= tx_next;
            rx_reg    <= rx_next;
            rdata_reg <= rdata_next;
            rw_reg    <= rw_next;
            done_reg  <= done_next;
        end
    end

    assign half_done = (div_reg == DIV_LAST);

    always_comb begin
        state_next = state_reg;
        div_next   = div_reg;
        edge_next  = edge_reg;
        sclk_next  = sclk_reg;
        cs_next    = cs_reg;
        mosi_next  = mosi_reg;
        tx_next    = tx_reg;
        rx_next    = rx_reg;
        rdata_next = rdata_reg;
        rw_next    = rw_reg;
        done_next  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    // Command MSB goes straight to mosi; tx holds the remaining 15 bits plus a trailing 0.
                    rw_next    = rw;
                    mosi_next  = addr[6];
                    tx_next    = {addr[5:0], rw, (rw ? 8'h00 : wdata), 1'b0};
                    cs_next    = 1'b0;
                    sclk_next  = 1'b0;
                    div_next   = '0;
                    edge_next  = '0;
                    rx_next    = '0;
                    state_next = S_CMD;
                end
            end
            S_CMD, S_DATA: begin
                if (half_done) begin
                    div_next  = '0;
                    sclk_next = ~sclk_reg;
                    if (!sclk_reg) begin
                        if (state_reg == S_DATA) rx_next = {rx_reg[6:0], miso_pin};
                    end else begin
                        mosi_next = tx_reg[15];
                        tx_next   = {tx_reg[14:0], 1'b0};
                        edge_next = edge_reg + 5'd1;
                        if (edge_reg == 5'd7)  state_next = S_DATA;
                        if (edge_reg == 5'd15) state_next = S_END;
                    end
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            S_END: begin
                if (half_done) begin
                    div_next  = '0;
                    edge_next = '0;
                    cs_next   = 1'b1;
                    done_next = 1'b1;
                    if (rw_reg) rdata_next = rx_reg;
`ifdef SPIM_CS_GAP_EN
                    state_next = S_GAP;
`else
                    state_next = S_IDLE;
`endif
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
`ifdef SPIM_CS_GAP_EN
            S_GAP: begin
                if (div_reg == GAP_LAST) begin
                    div_next   = '0;
                    state_next = S_IDLE;
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    assign busy     = (state_reg != S_IDLE);
    assign done     = done_reg;
    assign rdata    = rdata_reg;
    assign sclk_pin = sclk_reg;
    assign cs_pin   = cs_reg;
    assign mosi_pin = mosi_reg;

endmodule
